// File: rtl/dti_pack.sv
// Shared types for the DTI NoC interface: flit layout and receive-side FSM states.
// No logic; imported by the NoC rx buffer and the generic FIFO users.
// Widths here are the defaults; modules may override them through parameters.
package dti_pack;

  localparam int NOC_PAYLOAD_W = 90;
  localparam int NOC_ID_W      = 6;

  typedef struct packed {
    logic [NOC_PAYLOAD_W-1:0] payload;
    logic [NOC_ID_W-1:0]      srcid;
    logic [NOC_ID_W-1:0]      tgtid;
    logic                     qos;
    logic                     last;
  } noc_flit_t;

  typedef enum logic [1:0] {
    RX_HEAD,
    RX_PASS,
    RX_DROP
  } rx_state_e;

endpackage

// File: rtl/dti_sync_fifo.sv
// Generic synchronous FIFO with registered storage and occupancy count.
// Latency: a push is visible on pop_dat the following cycle.
// Backpressure: push is ignored when full, pop is ignored when empty.
module dti_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/dti_noc_rx_buf.sv
// NoC receive buffer: filters packets by target ID and queues local flits for the DTI top.
// Latency: one cycle from accepted flit to out_valid.
// Backpressure: in_ready follows FIFO full (discarded flits always accepted); out_threshold gates packet heads only.
module dti_noc_rx_buf
  import dti_pack::*;
#(
  parameter int DEPTH       = 8,
  parameter int THRESH_FREE = 4,
  parameter int PAYLOAD_W   = NOC_PAYLOAD_W,
  parameter int ID_W        = NOC_ID_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ID_W-1:0]      cfg_local_id,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [ID_W-1:0]      in_srcid,
  input  logic [ID_W-1:0]      in_tgtid,
  input  logic                 in_qos,
  input  logic                 in_last,
  output logic                 in_threshold,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [ID_W-1:0]      out_srcid,
  output logic [ID_W-1:0]      out_tgtid,
  output logic                 out_qos,
  output logic                 out_last,
  input  logic                 out_threshold,
  output logic [15:0]          drop_cnt,
  output logic                 drop_pulse,
  output logic                 idle
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [ID_W-1:0]      srcid;
    logic [ID_W-1:0]      tgtid;
    logic                 qos;
    logic                 last;
  } flit_t;

  rx_state_e state, state_nxt;
  flit_t     in_flit, head_flit;
  logic      fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] free_cnt;
  logic      id_match, discard, in_hs, push, pop, head_drop, mid_pkt;

  assign in_flit = '{payload: in_payload, srcid: in_srcid, tgtid: in_tgtid,
                     qos: in_qos, last: in_last};

  assign id_match  = (in_tgtid == cfg_local_id);
  assign discard   = ((state == RX_HEAD) && !id_match) || (state == RX_DROP);
  assign in_ready  = discard || !fifo_full;
  assign in_hs     = in_valid && in_ready;
  assign push      = in_hs && !discard;
  assign head_drop = in_hs && (state == RX_HEAD) && !id_match;

  assign free_cnt     = CW'(DEPTH) - fifo_count;
  assign in_threshold = (free_cnt >= CW'(THRESH_FREE));

  always_comb begin
    state_nxt = state;
    case (state)
      RX_HEAD: if (in_hs && !in_last) state_nxt = id_match ? RX_PASS : RX_DROP;
      RX_PASS: if (in_hs && in_last) state_nxt = RX_HEAD;
      RX_DROP: if (in_hs && in_last) state_nxt = RX_HEAD;
      default: state_nxt = RX_HEAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_HEAD;
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      drop_pulse <= head_drop;
      if (head_drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  dti_sync_fifo #(
    .WIDTH ($bits(flit_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (in_flit),
    .pop      (pop),
    .pop_dat  (head_flit),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Downstream threshold only gates a new packet head, never a started body.
  assign out_valid = !fifo_empty && (mid_pkt || out_threshold);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mid_pkt <= 1'b0;
    end else if (pop) begin
      mid_pkt <= !head_flit.last;
    end
  end

  assign out_payload = head_flit.payload;
  assign out_srcid   = head_flit.srcid;
  assign out_tgtid   = head_flit.tgtid;
  assign out_qos     = head_flit.qos;
  assign out_last    = head_flit.last;

  assign idle = fifo_empty && (state == RX_HEAD) && !mid_pkt;

endmodule

// File: tb/tb_dti_noc_rx_buf.sv
// Directed bench for dti_noc_rx_buf: vector table for pass/drop flow,
// hand sequences for fill/threshold, egress gating, counter saturation and reset.
module tb_dti_noc_rx_buf;

  localparam int PW = 90;
  localparam int IW = 6;
  localparam logic [IW-1:0] LOCAL = 6'h05;
  localparam logic [IW-1:0] OTHER = 6'h07;

  logic          clk;
  logic          rst_n;
  logic [IW-1:0] cfg_local_id;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_payload;
  logic [IW-1:0] in_srcid;
  logic [IW-1:0] in_tgtid;
  logic          in_qos;
  logic          in_last;
  logic          in_threshold;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_payload;
  logic [IW-1:0] out_srcid;
  logic [IW-1:0] out_tgtid;
  logic          out_qos;
  logic          out_last;
  logic          out_threshold;
  logic [15:0]   drop_cnt;
  logic          drop_pulse;
  logic          idle;

  int n_cmp = 0;
  int n_err = 0;

  dti_noc_rx_buf #(
    .DEPTH       (8),
    .THRESH_FREE (4),
    .PAYLOAD_W   (PW),
    .ID_W        (IW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_local_id  (cfg_local_id),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_payload    (in_payload),
    .in_srcid      (in_srcid),
    .in_tgtid      (in_tgtid),
    .in_qos        (in_qos),
    .in_last       (in_last),
    .in_threshold  (in_threshold),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_payload   (out_payload),
    .out_srcid     (out_srcid),
    .out_tgtid     (out_tgtid),
    .out_qos       (out_qos),
    .out_last      (out_last),
    .out_threshold (out_threshold),
    .drop_cnt      (drop_cnt),
    .drop_pulse    (drop_pulse),
    .idle          (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          vld;
    logic [IW-1:0] tgt;
    logic [PW-1:0] pay;
    logic          last;
    logic          e_rdy;
    logic          e_ovld;
    logic [PW-1:0] e_pay;
    logic          e_last;
    logic          e_pulse;
    logic          e_idle;
    logic [15:0]   e_cnt;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic vld, logic [IW-1:0] tgt, int pay, logic last,
                              logic e_rdy, logic e_ovld, int e_pay, logic e_last,
                              logic e_pulse, logic e_idle, int e_cnt);
    vec_t v;
    v.vld = vld; v.tgt = tgt; v.pay = PW'(pay); v.last = last;
    v.e_rdy = e_rdy; v.e_ovld = e_ovld; v.e_pay = PW'(e_pay); v.e_last = e_last;
    v.e_pulse = e_pulse; v.e_idle = e_idle; v.e_cnt = 16'(e_cnt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [IW-1:0] tgt, input int pay, input logic last);
    in_valid   = vld;
    in_tgtid   = tgt;
    in_payload = PW'(pay);
    in_srcid   = 6'h2A;
    in_qos     = 1'b0;
    in_last    = last;
  endtask

  initial begin
    rst_n         = 1'b0;
    cfg_local_id  = LOCAL;
    out_ready     = 1'b1;
    out_threshold = 1'b1;
    drive(1'b0, LOCAL, 0, 1'b0);

    // Reset state
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_in_threshold", in_threshold, 1'b1);
    chk("rst_drop_pulse", drop_pulse, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_drop_cnt", drop_cnt, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pass packet 1,2,3; drop a 2-flit foreign packet; pass a packet whose body has a foreign tgtid
    vecs[0]  = mk(0, LOCAL, 0,     0, 1, 0, 0,     0, 0, 1, 0);
    vecs[1]  = mk(1, LOCAL, 1,     0, 1, 0, 0,     0, 0, 1, 0);
    vecs[2]  = mk(1, LOCAL, 2,     0, 1, 1, 1,     0, 0, 0, 0);
    vecs[3]  = mk(1, LOCAL, 3,     1, 1, 1, 2,     0, 0, 0, 0);
    vecs[4]  = mk(0, LOCAL, 0,     0, 1, 1, 3,     1, 0, 0, 0);
    vecs[5]  = mk(0, LOCAL, 0,     0, 1, 0, 0,     0, 0, 1, 0);
    vecs[6]  = mk(1, OTHER, 'hA,   0, 1, 0, 0,     0, 0, 1, 0);
    vecs[7]  = mk(1, OTHER, 'hB,   1, 1, 0, 0,     0, 1, 0, 1);
    vecs[8]  = mk(1, LOCAL, 'hC,   0, 1, 0, 0,     0, 0, 1, 1);
    vecs[9]  = mk(1, OTHER, 'hD,   1, 1, 1, 'hC,   0, 0, 0, 1);
    vecs[10] = mk(0, LOCAL, 0,     0, 1, 1, 'hD,   1, 0, 0, 1);
    vecs[11] = mk(0, LOCAL, 0,     0, 1, 0, 0,     0, 0, 1, 1);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].vld, vecs[i].tgt, int'(vecs[i].pay), vecs[i].last);
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_rdy);
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ovld);
      if (vecs[i].e_ovld) begin
        chk($sformatf("vec%0d_out_payload", i), out_payload, vecs[i].e_pay);
        chk($sformatf("vec%0d_out_last", i), out_last, vecs[i].e_last);
      end
      chk($sformatf("vec%0d_drop_pulse", i), drop_pulse, vecs[i].e_pulse);
      chk($sformatf("vec%0d_idle", i), idle, vecs[i].e_idle);
      chk($sformatf("vec%0d_drop_cnt", i), drop_cnt, vecs[i].e_cnt);
      @(negedge clk);
    end

    // Fill to full with out_ready=0, watching the free-space threshold
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, LOCAL, 'h100 + i, 1'b1);
      #1;
      chk($sformatf("fill%0d_in_ready", i), in_ready, 1'b1);
      chk($sformatf("fill%0d_in_threshold", i), in_threshold, (8 - i) >= 4);
      @(negedge clk);
    end
    drive(1'b1, LOCAL, 'h1FF, 1'b1);
    out_ready = 1'b1;
    #1;
    chk("full_pop_in_ready", in_ready, 1'b0);
    chk("full_in_threshold", in_threshold, 1'b0);
    chk("full_out_valid", out_valid, 1'b1);
    chk("full_head", out_payload, PW'('h100));
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("after_pop_in_ready", in_ready, 1'b1);
    chk("after_pop_head", out_payload, PW'('h101));
    @(negedge clk);
    drive(1'b0, LOCAL, 0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("drain%0d_out_valid", i), out_valid, 1'b1);
      chk($sformatf("drain%0d_payload", i), out_payload, (i < 7) ? PW'('h101 + i) : PW'('h1FF));
      @(negedge clk);
    end
    #1;
    chk("drain_idle", idle, 1'b1);
    chk("drain_out_valid", out_valid, 1'b0);
    @(negedge clk);

    // Egress threshold gates heads only
    out_ready = 1'b0;
    drive(1'b1, LOCAL, 'h21, 1'b0); @(negedge clk);
    drive(1'b1, LOCAL, 'h22, 1'b1); @(negedge clk);
    drive(1'b1, LOCAL, 'h31, 1'b0); @(negedge clk);
    drive(1'b1, LOCAL, 'h32, 1'b1); @(negedge clk);
    drive(1'b0, LOCAL, 0, 1'b0);
    out_threshold = 1'b0;
    out_ready     = 1'b1;
    #1;
    chk("thr0_hold_a", out_valid, 1'b0);
    @(negedge clk);
    #1;
    chk("thr0_hold_b", out_valid, 1'b0);
    @(negedge clk);
    out_threshold = 1'b1;
    #1;
    chk("thr1_head_valid", out_valid, 1'b1);
    chk("thr1_head_pay", out_payload, PW'('h21));
    @(negedge clk);
    out_threshold = 1'b0;
    #1;
    chk("body_valid_thr0", out_valid, 1'b1);
    chk("body_pay", out_payload, PW'('h22));
    chk("body_last", out_last, 1'b1);
    @(negedge clk);
    #1;
    chk("next_head_held_a", out_valid, 1'b0);
    @(negedge clk);
    #1;
    chk("next_head_held_b", out_valid, 1'b0);
    out_threshold = 1'b1;
    #1;
    chk("next_head_valid", out_valid, 1'b1);
    chk("next_head_pay", out_payload, PW'('h31));
    @(negedge clk);
    #1;
    chk("next_body_pay", out_payload, PW'('h32));
    @(negedge clk);
    #1;
    chk("egress_idle", idle, 1'b1);

    // Drop counter saturation (count is 1 here)
    @(negedge clk);
    drive(1'b1, OTHER, 'hEE, 1'b1);
    repeat (65533) @(negedge clk);
    #1;
    chk("sat_pre_cnt", drop_cnt, 16'hFFFE);
    @(negedge clk);
    #1;
    chk("sat_cnt", drop_cnt, 16'hFFFF);
    chk("sat_pulse", drop_pulse, 1'b1);
    @(negedge clk);
    #1;
    chk("sat_hold_cnt", drop_cnt, 16'hFFFF);
    chk("sat_hold_pulse", drop_pulse, 1'b1);
    drive(1'b0, LOCAL, 0, 1'b0);
    @(negedge clk);
    #1;
    chk("sat_pulse_clear", drop_pulse, 1'b0);
    chk("sat_cnt_stay", drop_cnt, 16'hFFFF);
    @(negedge clk);

    // Reset mid-packet with three entries queued
    out_ready = 1'b0;
    drive(1'b1, LOCAL, 'h41, 1'b0); @(negedge clk);
    drive(1'b1, LOCAL, 'h42, 1'b0); @(negedge clk);
    drive(1'b1, LOCAL, 'h43, 1'b0); @(negedge clk);
    drive(1'b0, LOCAL, 0, 1'b0);
    #1;
    chk("pre_rst_out_valid", out_valid, 1'b1);
    chk("pre_rst_idle", idle, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_idle", idle, 1'b1);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_in_threshold", in_threshold, 1'b1);
    chk("mid_rst_drop_cnt", drop_cnt, 16'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, LOCAL, 'h51, 1'b1);
    @(negedge clk);
    drive(1'b0, LOCAL, 0, 1'b0);
    #1;
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_pay", out_payload, PW'('h51));
    chk("post_rst_last", out_last, 1'b1);
    @(negedge clk);
    #1;
    chk("post_rst_idle", idle, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
